apb_check_master: RTL and testbench
===================================

# apb_check_master

Parametrised APB3 master engine for the SSP subsystem. It drains a queue of register commands (write, read, read-and-compare) onto an APB bus and reports per-command status. It keeps pass/fail counters, so register reset-value and read/write sweeps run in hardware rather than through procedural bus tasks. It adds PREADY wait states, PSLVERR capture, access timeout and masked compare, none of which the fixed two-phase bus access provides.

## Interface
Parameters:
- ADDR_W, 12, byte-address width of PADDR; command address is the word address [ADDR_W-1:2]
- DATA_W, 32, width of PWDATA/PRDATA and the data/expect/mask fields
- CMD_DEPTH, 8, command FIFO depth; power of two, ≥2
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; ≥1

Ports:
- PCLK  in  1  single clock, all logic rising-edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  2  00 write, 01 read, 10 read-check, 11 reserved (treated as read)
- cmd_addr  in  ADDR_W-2  word address
- cmd_wdata  in  DATA_W  write data
- cmd_exp  in  DATA_W  expected read value
- cmd_mask  in  DATA_W  compare mask
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  {cmd_addr, 2'b00}
- PWDATA  out  DATA_W  write data
- PRDATA  in  DATA_W  read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error
- rsp_valid  out  1  one-cycle response strobe
- rsp_status  out  2  00 ok, 01 mismatch, 10 slverr, 11 timeout
- rsp_rdata  out  DATA_W  PRDATA sampled at completion (0 on timeout/write)
- pass_cnt, fail_cnt  out  16 each  saturating counters
- clr_cnt  in  1  clear both counters
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Command FIFO: push on cmd_valid&&cmd_ready; cmd_ready = !full; pop in IDLE when non-empty. Simultaneous push and pop are both performed; occupancy unchanged. Read and write pointers wrap modulo CMD_DEPTH.
- FSM IDLE → SETUP → ACCESS → IDLE.
  - IDLE: PSEL=PENABLE=0, PADDR=PWDATA=0. If FIFO non-empty, pop the command into the holding register and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PWRITE=(op==00). PWDATA=cmd_wdata for writes, 0 for reads. Unconditionally go to ACCESS.
  - ACCESS: PENABLE=1. PADDR/PWRITE/PWDATA are held stable from SETUP. When PREADY=1, complete and return to IDLE. The timeout counter increments on each ACCESS cycle with PREADY=0; when it reaches TIMEOUT, abort and return to IDLE.
- Status on completion, in priority order: timeout → 11; PSLVERR → 10; op 10 with (PRDATA&mask)!=(exp&mask) → 01; else 00.
- The cycle after completion:
  - rsp_valid=1 for exactly one cycle, with rsp_status and rsp_rdata.
  - pass_cnt increments on status 00; fail_cnt increments otherwise.
  - Counters saturate at 0xFFFF.
  - clr_cnt in the same cycle wins: counters become 0 and the increment is lost.

## Timing
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=0, rsp_status=0, rsp_rdata=0, counters=0, FIFO empty, cmd_ready=1, busy=0, FSM IDLE.
- PRESET asserted mid-transfer: all outputs return to reset values at the next edge. The in-flight command and all queued commands are discarded; no response is issued.
- Push into empty FIFO at edge E0: IDLE pops at E1, PSEL rises after E1, PENABLE rises after E2.
- Zero-wait transfer: SETUP 1 cycle, ACCESS 1 cycle, then IDLE with rsp_valid. Back-to-back commands therefore take 3 cycles each.
- With n wait cycles (PREADY low), ACCESS lasts n+1 cycles.
- Timeout: ACCESS lasts exactly TIMEOUT cycles. PSEL/PENABLE drop at the following edge.
- PRDATA, PSLVERR and PREADY are sampled only in ACCESS. Values in other states are ignored.
- All outputs are registered; no combinational path from APB inputs to APB outputs.

## Test plan
- Write word 0x000 data 0x00C7, PREADY=1 → PSEL high 2 cycles, PENABLE 1 cycle, PADDR=0x000, PWRITE=1; rsp_status=00, pass_cnt=1.
- Read-check word 0x3F8, exp 0x22, mask 0xFF; slave returns 0x1122 → status 00, rsp_rdata=0x1122. Same with mask 0x1F, exp 0x03, slave returns 0x02 → status 01, fail_cnt=1.
- PREADY low 3 cycles on a read → PENABLE high 4 cycles, single rsp_valid. PSLVERR=1 at completion → status 10.
- TIMEOUT=4, PREADY never high → abort after 4 ACCESS cycles, status 11, rsp_rdata=0, next queued command proceeds normally.
- Slave stalled; push 9 commands → first 8 accepted, cmd_ready low from the 8th handshake until the first pop. Draining yields 8 responses in order and busy falls after the last.
- PRESET during ACCESS with 3 queued commands → next edge PSEL=0, busy=0, counters 0, no rsp_valid. clr_cnt coincident with rsp_valid → counters read 0.

Source files
------------

// File: rtl/apb_check_master.sv
// APB3 master that drains a queue of write / read / read-compare commands
// and reports per-command status with saturating pass/fail counters.
module apb_check_master #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-3:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_exp,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt,
  input  logic              clr_cnt,
  output logic              busy
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_CHK = 2'b10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_n;

  logic [1:0]        q_op   [CMD_DEPTH];
  logic [ADDR_W-3:0] q_addr [CMD_DEPTH];
  logic [DATA_W-1:0] q_wdata[CMD_DEPTH];
  logic [DATA_W-1:0] q_exp  [CMD_DEPTH];
  logic [DATA_W-1:0] q_mask [CMD_DEPTH];

  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop, done;

  logic [1:0]        f_op, op_q;
  logic [ADDR_W-3:0] f_addr;
  logic [DATA_W-1:0] f_wdata, f_exp, f_mask, exp_q, mask_q;
  logic [TW-1:0]     tcnt;

  logic              psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n, rdata_n;
  logic [1:0]        status_n;

  // Extra pointer bit separates full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign busy      = !empty || (state != IDLE);

  assign f_op    = q_op   [rd_ptr[PW-1:0]];
  assign f_addr  = q_addr [rd_ptr[PW-1:0]];
  assign f_wdata = q_wdata[rd_ptr[PW-1:0]];
  assign f_exp   = q_exp  [rd_ptr[PW-1:0]];
  assign f_mask  = q_mask [rd_ptr[PW-1:0]];

  always_ff @(posedge PCLK) begin
    if (push) begin
      q_op   [wr_ptr[PW-1:0]] <= cmd_op;
      q_addr [wr_ptr[PW-1:0]] <= cmd_addr;
      q_wdata[wr_ptr[PW-1:0]] <= cmd_wdata;
      q_exp  [wr_ptr[PW-1:0]] <= cmd_exp;
      q_mask [wr_ptr[PW-1:0]] <= cmd_mask;
    end
  end

  // Bus outputs are computed for the next state and then registered.
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    done      = 1'b0;
    psel_n    = 1'b0;
    penable_n = 1'b0;
    pwrite_n  = 1'b0;
    paddr_n   = '0;
    pwdata_n  = '0;
    status_n  = 2'b00;
    rdata_n   = '0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_n  = SETUP;
          psel_n   = 1'b1;
          pwrite_n = (f_op == OP_WR);
          paddr_n  = {f_addr, 2'b00};
          pwdata_n = (f_op == OP_WR) ? f_wdata : '0;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        psel_n    = 1'b1;
        penable_n = 1'b1;
        pwrite_n  = PWRITE;
        paddr_n   = PADDR;
        pwdata_n  = PWDATA;
      end
      ACCESS: begin
        psel_n    = 1'b1;
        penable_n = 1'b1;
        pwrite_n  = PWRITE;
        paddr_n   = PADDR;
        pwdata_n  = PWDATA;
        if (PREADY || tcnt == TW'(TIMEOUT - 1)) begin
          state_n   = IDLE;
          done      = 1'b1;
          psel_n    = 1'b0;
          penable_n = 1'b0;
          pwrite_n  = 1'b0;
          paddr_n   = '0;
          pwdata_n  = '0;
          if (!PREADY) begin
            status_n = 2'b11;
          end else begin
            rdata_n = PWRITE ? '0 : PRDATA;
            if (PSLVERR)
              status_n = 2'b10;
            else if (op_q == OP_CHK &&
                     ((PRDATA ^ exp_q) & mask_q) != '0)
              status_n = 2'b01;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      op_q       <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
      tcnt       <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= 2'b00;
      rsp_rdata  <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      state   <= state_n;
      PSEL    <= psel_n;
      PENABLE <= penable_n;
      PWRITE  <= pwrite_n;
      PADDR   <= paddr_n;
      PWDATA  <= pwdata_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        op_q   <= f_op;
        exp_q  <= f_exp;
        mask_q <= f_mask;
      end
      if (state != ACCESS) tcnt <= '0;
      else if (!PREADY)    tcnt <= tcnt + TW'(1);
      rsp_valid <= done;
      if (done) begin
        rsp_status <= status_n;
        rsp_rdata  <= rdata_n;
      end
      // Counters follow the response strobe; a clear in that cycle wins.
      if (clr_cnt) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
      end else if (rsp_valid) begin
        if (rsp_status == 2'b00) begin
          if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
        end else begin
          if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_check_master.sv
// Bench for apb_check_master: APB slave model, response scoreboard,
// vector table plus hand sequences for timing, fill, reset and clear.
module tb_apb_check_master;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-3:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, cmd_exp = '0, cmd_mask = '0;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0, PSLVERR = 1'b0;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [DW-1:0] rsp_rdata;
  logic [15:0]   pass_cnt, fail_cnt;
  logic          clr_cnt = 1'b0;
  logic          busy;

  always #5 PCLK = ~PCLK;

  apb_check_master #(
    .ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_exp(cmd_exp), .cmd_mask(cmd_mask),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_rdata(rsp_rdata), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .clr_cnt(clr_cnt), .busy(busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [9:0]  addr;
    logic [31:0] wdata, expv, mask, prdata;
    int          waits;
    logic        slverr;
    logic [1:0]  st;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] rd;
    int          acc;
  } sb_t;

  typedef struct {
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata, prdata;
    int          waits;
    logic        slverr;
  } sl_t;

  sb_t sb_q[$];
  sl_t sl_q[$];
  int  tests = 0;
  int  fails = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [9:0] a,
      input logic [31:0] wd, input logic [31:0] ex, input logic [31:0] mk_,
      input logic [31:0] pr, input int w, input logic se,
      input logic [1:0] st, input logic [31:0] rd);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.expv = ex; v.mask = mk_;
    v.prdata = pr; v.waits = w; v.slverr = se; v.st = st; v.rd = rd;
    return v;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Queue expectations, then hold the command until the FIFO takes it.
  task automatic send(input vec_t v, output int stalls);
    sb_t  e;
    sl_t  s;
    logic ok;
    e.st  = v.st;
    e.rd  = v.rd;
    e.acc = (v.st == 2'b11) ? TO : v.waits + 1;
    s.paddr  = {v.addr, 2'b00};
    s.pwrite = (v.op == 2'b00);
    s.pwdata = s.pwrite ? v.wdata : 32'h0;
    s.prdata = v.prdata;
    s.waits  = v.waits;
    s.slverr = v.slverr;
    sb_q.push_back(e);
    sl_q.push_back(s);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_exp   = v.expv;
    cmd_mask  = v.mask;
    stalls = 0;
    forever begin
      ok = cmd_ready;
      tick();
      if (ok) break;
      stalls++;
      if (stalls > 200) begin
        chk("cmd_accept", {31'b0, ok}, 32'h1);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_left", sb_q.size(), 0);
  endtask

  // APB slave: drives PREADY/PRDATA/PSLVERR just after each rising edge.
  initial begin : slave
    sl_t cur;
    int  left;
    logic active;
    active = 1'b0;
    left = 0;
    forever begin
      tick();
      if (PSEL === 1'b1 && PENABLE === 1'b0) begin
        if (sl_q.size() == 0) begin
          chk("unexpected_setup", {31'b0, PSEL}, 32'h0);
          active = 1'b0;
        end else begin
          cur = sl_q.pop_front();
          left = cur.waits;
          active = 1'b1;
          chk("setup_paddr", PADDR, cur.paddr);
          chk("setup_pwrite", {31'b0, PWRITE}, {31'b0, cur.pwrite});
          chk("setup_pwdata", PWDATA, cur.pwdata);
        end
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hBAD0_0BAD;
      end else if (PSEL === 1'b1 && PENABLE === 1'b1 && active) begin
        chk("access_paddr", PADDR, cur.paddr);
        chk("access_pwrite", {31'b0, PWRITE}, {31'b0, cur.pwrite});
        chk("access_pwdata", PWDATA, cur.pwdata);
        if (left > 0) begin
          PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hBAD1_1BAD;
          left--;
        end else begin
          PREADY = 1'b1; PSLVERR = cur.slverr; PRDATA = cur.prdata;
        end
      end else begin
        active = 1'b0;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hDEAD_BEEF;
      end
    end
  end

  // Response scoreboard and counter model, sampled on falling edges.
  initial begin : monitor
    sb_t e;
    logic [31:0] mp, mf;
    logic [1:0] st_e;
    logic have;
    int acc_n, sel_n;
    mp = 0; mf = 0; acc_n = 0; sel_n = 0;
    forever begin
      @(negedge PCLK);
      if (mon_en) begin
        have = 1'b0;
        st_e = 2'b00;
        if (PENABLE) acc_n++;
        if (PSEL) sel_n++;
        chk("pass_cnt", {16'b0, pass_cnt}, mp);
        chk("fail_cnt", {16'b0, fail_cnt}, mf);
        if (rsp_valid) begin
          if (sb_q.size() == 0) begin
            chk("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_status", {30'b0, rsp_status}, {30'b0, e.st});
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("access_cycles", acc_n, e.acc);
            chk("psel_cycles", sel_n, e.acc + 1);
            st_e = e.st;
            have = 1'b1;
          end
          acc_n = 0;
          sel_n = 0;
        end
        if (PRESET || clr_cnt) begin
          mp = 0;
          mf = 0;
        end else if (have) begin
          if (st_e == 2'b00) mp = mp + 1;
          else mf = mf + 1;
        end
        if (PRESET) begin
          acc_n = 0;
          sel_n = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[13];
    vec_t v;
    int   st, gap, c0, c1, n;

    tbl[0]  = mk(2'b10, 10'h3F8, 0, 32'h22, 32'hFF, 32'h1122,
                 0, 0, 2'b00, 32'h1122);
    tbl[1]  = mk(2'b10, 10'h3F8, 0, 32'h03, 32'h1F, 32'h02,
                 0, 0, 2'b01, 32'h02);
    tbl[2]  = mk(2'b01, 10'h010, 32'hFFFF_0000, 0, 0, 32'hA5A5_0001,
                 3, 0, 2'b00, 32'hA5A5_0001);
    tbl[3]  = mk(2'b01, 10'h011, 0, 0, 0, 32'h55,
                 3, 1, 2'b10, 32'h55);
    tbl[4]  = mk(2'b00, 10'h020, 32'h1234, 0, 0, 32'h9999,
                 0, 1, 2'b10, 32'h0);
    tbl[5]  = mk(2'b11, 10'h021, 0, 0, 32'hFFFF_FFFF, 32'h77,
                 0, 0, 2'b00, 32'h77);
    tbl[6]  = mk(2'b10, 10'h100, 0, 32'hCAFE_F00D, 32'hFFFF_FFFF,
                 32'hCAFE_F00D, 2, 0, 2'b00, 32'hCAFE_F00D);
    tbl[7]  = mk(2'b10, 10'h101, 0, 32'h8000_0000, 32'h8000_0000, 32'h0,
                 0, 0, 2'b01, 32'h0);
    tbl[8]  = mk(2'b10, 10'h102, 0, 32'h1, 32'h0, 32'hFFFF,
                 1, 0, 2'b00, 32'hFFFF);
    tbl[9]  = mk(2'b10, 10'h103, 0, 32'h1, 32'h1, 32'h0,
                 0, 1, 2'b10, 32'h0);
    tbl[10] = mk(2'b01, 10'h200, 0, 0, 0, 32'h44,
                 255, 0, 2'b11, 32'h0);
    tbl[11] = mk(2'b00, 10'h201, 32'hFFFF_FFFF, 0, 0, 32'h5,
                 1, 0, 2'b00, 32'h0);
    tbl[12] = mk(2'b01, 10'h202, 0, 0, 0, 32'h0F0F,
                 TO - 1, 0, 2'b00, 32'h0F0F);

    // Reset state
    repeat (3) tick();
    chk("rst_psel", {31'b0, PSEL}, 32'h0);
    chk("rst_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_pwrite", {31'b0, PWRITE}, 32'h0);
    chk("rst_paddr", {20'b0, PADDR}, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_status", {30'b0, rsp_status}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    mon_en = 1'b1;
    PRESET = 1'b0;
    tick();

    // Single zero-wait write: cycle-exact bus phases
    v = mk(2'b00, 10'h000, 32'h00C7, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    send(v, st);
    tick();
    chk("wr_setup_psel", {31'b0, PSEL}, 32'h1);
    chk("wr_setup_penable", {31'b0, PENABLE}, 32'h0);
    chk("wr_setup_pwrite", {31'b0, PWRITE}, 32'h1);
    chk("wr_setup_pwdata", PWDATA, 32'h00C7);
    chk("wr_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("wr_access_psel", {31'b0, PSEL}, 32'h1);
    chk("wr_access_penable", {31'b0, PENABLE}, 32'h1);
    tick();
    chk("wr_done_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("wr_done_psel", {31'b0, PSEL}, 32'h0);
    chk("wr_idle_pwdata", PWDATA, 32'h0);
    tick();
    chk("wr_rsp_one_cycle", {31'b0, rsp_valid}, 32'h0);
    chk("wr_pass_cnt", {16'b0, pass_cnt}, 32'h1);

    // Back-to-back zero-wait commands complete 3 cycles apart
    send(mk(2'b00, 10'h004, 32'h1, 0, 0, 0, 0, 0, 2'b00, 0), st);
    send(mk(2'b00, 10'h005, 32'h2, 0, 0, 0, 0, 0, 2'b00, 0), st);
    c0 = -1; c1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        if (c0 < 0) c0 = i;
        else if (c1 < 0) c1 = i;
      end
      tick();
    end
    gap = c1 - c0;
    chk("b2b_gap", gap, 3);
    drain();

    // Vector table
    for (int i = 0; i < 13; i++) send(tbl[i], st);
    drain();
    chk("table_busy_after", {31'b0, busy}, 32'h0);

    // FIFO fill behind a stalled transfer
    send(mk(2'b01, 10'h300, 0, 0, 0, 0, 255, 0, 2'b11, 0), st);
    for (int i = 0; i < 8; i++)
      send(mk(2'b01, 10'h301 + 10'(i), 0, 0, 0, 32'h100 + i,
              0, 0, 2'b00, 32'h100 + i), st);
    chk("full_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    chk("full_busy", {31'b0, busy}, 32'h1);
    send(mk(2'b01, 10'h30A, 0, 0, 0, 32'h1FF, 0, 0, 2'b00, 32'h1FF), st);
    chk("full_stalled", {31'b0, st > 0}, 32'h1);
    drain();
    chk("fill_busy_after", {31'b0, busy}, 32'h0);

    // Reset during ACCESS with commands queued
    send(mk(2'b01, 10'h3A0, 0, 0, 0, 0, 255, 0, 2'b11, 0), st);
    for (int i = 0; i < 3; i++)
      send(mk(2'b01, 10'h3A1, 0, 0, 0, 32'h9, 0, 0, 2'b00, 32'h9), st);
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin
      tick();
      n++;
    end
    chk("rst_mid_in_access", {31'b0, PENABLE}, 32'h1);
    PRESET = 1'b1;
    sb_q.delete();
    sl_q.delete();
    tick();
    PRESET = 1'b0;
    chk("rst_mid_psel", {31'b0, PSEL}, 32'h0);
    chk("rst_mid_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_pass", {16'b0, pass_cnt}, 32'h0);
    chk("rst_mid_fail", {16'b0, fail_cnt}, 32'h0);
    chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'h0);
      tick();
    end

    // Clear coincident with the response strobe
    send(mk(2'b01, 10'h040, 0, 0, 0, 32'h3, 0, 0, 2'b00, 32'h3), st);
    drain();
    tick();
    chk("clr_pre_pass", {16'b0, pass_cnt}, 32'h1);
    send(mk(2'b10, 10'h041, 0, 32'h1, 32'h1, 32'h0, 0, 0, 2'b01, 32'h0), st);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("clr_rsp_seen", {31'b0, rsp_valid}, 32'h1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_pass", {16'b0, pass_cnt}, 32'h0);
    chk("clr_fail", {16'b0, fail_cnt}, 32'h0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
